// File: rtl/v850_pkg.sv
// Shared MEM-stage types for the V850 pipeline: operation codes, FSM states
// and lane/alignment helpers used by memory_access_unit and load_aligner.
package v850_pkg;

   typedef enum logic [3:0] {
      MEM_NONE  = 4'd0,
      MEM_LD_B  = 4'd1,
      MEM_LD_BU = 4'd2,
      MEM_LD_H  = 4'd3,
      MEM_LD_HU = 4'd4,
      MEM_LD_W  = 4'd5,
      MEM_ST_B  = 4'd6,
      MEM_ST_H  = 4'd7,
      MEM_ST_W  = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } mem_state_t;

   // Unused codes 9-15 collapse to a plain pass-through.
   function automatic mem_op_t decode_op(input logic [3:0] code);
      if (code > 4'd8) return MEM_NONE;
      return mem_op_t'(code);
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return (op == MEM_ST_B) || (op == MEM_ST_H) || (op == MEM_ST_W);
   endfunction

   function automatic logic is_load(input mem_op_t op);
      return (op == MEM_LD_B) || (op == MEM_LD_BU) || (op == MEM_LD_H) ||
             (op == MEM_LD_HU) || (op == MEM_LD_W);
   endfunction

   function automatic logic misaligned(input mem_op_t op, input logic [1:0] addr);
      case (op)
         MEM_LD_H, MEM_LD_HU, MEM_ST_H: return addr[0];
         MEM_LD_W, MEM_ST_W:            return |addr;
         default:                       return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_enable(input mem_op_t op, input logic [1:0] addr);
      case (op)
         MEM_LD_B, MEM_LD_BU, MEM_ST_B: return 4'b0001 << addr;
         MEM_LD_H, MEM_LD_HU, MEM_ST_H: return 4'b0011 << {addr[1], 1'b0};
         MEM_LD_W, MEM_ST_W:            return 4'b1111;
         default:                       return 4'b0000;
      endcase
   endfunction

   // Stores replicate the datum across every lane so the byte enables pick it.
   function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] data);
      case (op)
         MEM_ST_B: return {4{data[7:0]}};
         MEM_ST_H: return {2{data[15:0]}};
         MEM_ST_W: return data;
         default:  return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data aligner: shifts the addressed lane down and
// sign- or zero-extends it according to the load width.
module load_aligner
   import v850_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  mem_op_t     op,
   output logic [31:0] load_data
);

   logic [31:0] lane;

   always_comb begin
      lane = rdata >> {addr, 3'b000};
      case (op)
         MEM_LD_B:  load_data = {{24{lane[7]}}, lane[7:0]};
         MEM_LD_BU: load_data = {24'd0, lane[7:0]};
         MEM_LD_H:  load_data = {{16{lane[15]}}, lane[15:0]};
         MEM_LD_HU: load_data = {16'd0, lane[15:0]};
         default:   load_data = lane;
      endcase
   end

endmodule

// File: rtl/memory_access_unit.sv
// V850 MEM stage: single-outstanding req/ack bus access for loads/stores and
// 1-cycle pass-through of non-memory results. Optional MEM_TIMEOUT_EN adds
// an ack timeout with a timeout_o pulse.
module memory_access_unit
   import v850_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        mem_op_i,
   input  logic [31:0]       result_i,
   input  logic [31:0]       result2_i,
   input  logic [4:0]        destination_i,
   input  logic [4:0]        destination2_i,
   input  logic [ADDR_W-1:0] memory_address_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic [31:0]       bus_rdata_i,
   input  logic              bus_ack_i,
   output logic              wb_valid_o,
   output logic [4:0]        wb_dest_o,
   output logic [31:0]       wb_data_o,
   output logic [4:0]        wb_dest2_o,
   output logic [31:0]       wb_data2_o,
   output logic              misalign_o
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              timeout_o
`endif
);

   mem_state_t        state_q, state_d;
   mem_op_t           op_in;
   logic              accept, in_mem, in_misalign, timeout_hit;

   mem_op_t           op_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       res_p0;
   logic [4:0]        dest_p0;

   logic [31:0]       load_data;
   logic [4:0]        wb_dest_d, wb_dest2_d;
   logic [31:0]       wb_data_d, wb_data2_d;
   logic              misalign_d;

   assign op_in       = decode_op(mem_op_i);
   assign accept      = valid_i & ready_o;
   assign in_mem      = (op_in != MEM_NONE);
   assign in_misalign = misaligned(op_in, memory_address_i[1:0]);

   // Stage p0: EX outputs captured on accept; only control is reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0   <= op_in;
         addr_p0 <= memory_address_i;
         res_p0  <= result_i;
         dest_p0 <= destination_i;
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] to_cnt_q;
   logic       timeout_d;

   always_ff @(posedge clk) begin
      if (rst || state_q != ST_BUS) to_cnt_q <= 8'd0;
      else if (!bus_ack_i)          to_cnt_q <= to_cnt_q + 8'd1;
   end

   // Fires on the BUS cycle whose unacked increment would reach the limit.
   assign timeout_hit = (state_q == ST_BUS) && !bus_ack_i &&
                        (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = (in_mem && !in_misalign) ? ST_BUS : ST_RESP;
         ST_BUS:  if (bus_ack_i || timeout_hit) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready_o     = (state_q == ST_IDLE);
      bus_req_o   = (state_q == ST_BUS);
      bus_we_o    = bus_req_o & is_store(op_p0);
      bus_addr_o  = '0;
      bus_be_o    = 4'd0;
      bus_wdata_o = 32'd0;
      if (bus_req_o) begin
         bus_addr_o  = {addr_p0[ADDR_W-1:2], 2'b00};
         bus_be_o    = byte_enable(op_p0, addr_p0[1:0]);
         bus_wdata_o = store_data(op_p0, res_p0);
      end
   end

   load_aligner u_load_aligner (
      .rdata     (bus_rdata_i),
      .addr      (addr_p0[1:0]),
      .op        (op_p0),
      .load_data (load_data)
   );

   always_comb begin
      wb_dest_d  = 5'd0;
      wb_data_d  = 32'd0;
      wb_dest2_d = 5'd0;
      wb_data2_d = 32'd0;
      misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
      timeout_d  = 1'b0;
`endif
      if (state_q == ST_IDLE && accept) begin
         if (!in_mem) begin
            wb_dest_d  = destination_i;
            wb_data_d  = result_i;
            wb_dest2_d = destination2_i;
            wb_data2_d = result2_i;
         end else if (in_misalign) begin
            misalign_d = 1'b1;
         end
      end else if (state_q == ST_BUS) begin
         if (bus_ack_i) begin
            if (is_load(op_p0)) begin
               wb_dest_d = dest_p0;
               wb_data_d = load_data;
            end
         end else if (timeout_hit) begin
`ifdef MEM_TIMEOUT_EN
            timeout_d = 1'b1;
`endif
         end
      end
   end

   // Stage p1: writeback registers, zero except during the response pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_o <= 1'b0;
         wb_dest_o  <= 5'd0;
         wb_data_o  <= 32'd0;
         wb_dest2_o <= 5'd0;
         wb_data2_o <= 32'd0;
         misalign_o <= 1'b0;
      end else begin
         wb_valid_o <= (state_d == ST_RESP);
         wb_dest_o  <= wb_dest_d;
         wb_data_o  <= wb_data_d;
         wb_dest2_o <= wb_dest2_d;
         wb_data2_o <= wb_data2_d;
         misalign_o <= misalign_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) timeout_o <= 1'b0;
      else     timeout_o <= timeout_d;
   end
`endif

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- MEM stage of the V850 pipeline; consumes EX-stage outputs (result, result2, destination numbers, memory address).
- Loads/stores run as single-outstanding bus transactions with a req/ack handshake; loaded data is aligned and sign/zero-extended.
- Non-memory results pass through to writeback with 1-cycle latency.
- Back-pressures EX via ready_o while a bus transaction is pending.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, ack wait limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  EX output valid
- ready_o  out  1  stage can accept; high only in IDLE
- mem_op_i  in  4  operation select; encoding below
- result_i  in  32  EX primary result; also store data for ST.*
- result2_i  in  32  EX secondary result (DIV remainder, MUL high word)
- destination_i  in  5  primary destination register number
- destination2_i  in  5  secondary destination register number
- memory_address_i  in  ADDR_W  effective address from EX
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_W  word-aligned address; low 2 bits = 0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  write data, lane-replicated
- bus_rdata_i  in  32  read data; valid in the cycle bus_ack_i is high
- bus_ack_i  in  1  transaction complete
- wb_valid_o  out  1  writeback strobe, 1-cycle pulse
- wb_dest_o  out  5  primary write register; 0 = no write
- wb_data_o  out  32  primary write data
- wb_dest2_o  out  5  secondary write register; 0 = no write
- wb_data2_o  out  32  secondary write data
- misalign_o  out  1  misaligned-access pulse, concurrent with wb_valid_o
- timeout_o  out  1  bus timeout pulse; exists only when MEM_TIMEOUT_EN is defined

Behaviour:
- mem_op encoding: 0 NONE, 1 LD.B, 2 LD.BU, 3 LD.H, 4 LD.HU, 5 LD.W, 6 ST.B, 7 ST.H, 8 ST.W. Codes 9-15 are treated as NONE.
- Reset: state IDLE; all outputs 0 except ready_o = 1.
- States: IDLE, BUS, RESP.
- Accept = valid_i & ready_o. All inputs are registered on accept.
- NONE:
  - IDLE -> RESP.
  - Next cycle: wb_valid_o = 1; wb_dest/data = destination_i/result_i; wb_dest2/data2 = destination2_i/result2_i.
- Alignment: H requires addr[0] = 0; W requires addr[1:0] = 0.
  - Misaligned -> RESP directly, no bus cycle.
  - Response: wb_valid_o = 1, misalign_o = 1, wb_dest_o = wb_dest2_o = 0.
- Aligned load/store: IDLE -> BUS.
  - bus_req_o is held at 1 with addr/we/be/wdata stable until bus_ack_i is sampled high.
  - Then -> RESP and bus_req_o drops on the following edge.
  - Minimum 1 wait cycle between accept and req.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
- Write data:
  - ST.B: result_i[7:0] replicated x4.
  - ST.H: result_i[15:0] replicated x2.
  - ST.W: result_i unchanged.
- Load data: lane = bus_rdata_i >> (8*addr[1:0]), captured on the ack cycle.
  - B: sign-extend lane[7:0]; BU: zero-extend lane[7:0].
  - H: sign-extend lane[15:0]; HU: zero-extend lane[15:0].
  - W: lane unchanged.
- Load response: wb_dest_o = destination_i; wb_dest2_o = 0.
- Store response: wb_valid_o = 1 with wb_dest_o = wb_dest2_o = 0 (retire marker).
- RESP -> IDLE after 1 cycle; ready_o = 1 again the cycle after the wb_valid_o pulse.
- Boundary conditions:
  - Load to r0: the bus cycle still occurs; wb_dest_o = 0.
  - bus_ack_i while not in BUS: ignored.
  - rst during BUS: bus_req_o = 0 at the next edge; no wb_valid_o; a late ack is ignored.
  - valid_i while busy: not accepted; EX must hold its outputs.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter is cleared on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: -> RESP, timeout_o = 1, wb_dest_o = wb_dest2_o = 0, bus_req_o dropped.
- MEM_TIMEOUT_EN undefined: no counter, no timeout_o port; BUS waits for ack indefinitely.

Decomposition:
- Shared package v850_pkg: mem_op_t enum (codes above), mem_state_t enum, function byte_enable(op, addr).
- Sub-module load_aligner (combinational): rdata, addr[1:0], op -> 32-bit extended load data.

Test Plan:
- NONE: result_i = 0x1234_5678, dest = 5, result2_i = 0xA, dest2 = 6 -> next cycle wb_valid_o = 1, wb_dest 5/0x12345678, wb_dest2 6/0xA.
- LD.B at addr 0x1003, rdata = 0x80FF_0000, ack after 3 cycles -> be = 4'b1000, wb_data_o = 0xFFFF_FF80; ready_o low throughout.
- LD.HU at addr 0x2002, rdata = 0x8001_0000 -> be = 4'b1100, wb_data_o = 0x0000_8001; LD.H at the same address -> 0xFFFF_8001.
- ST.B at addr 0x0001, result_i = 0xAB -> bus_we_o = 1, be = 4'b0010, wdata = 0xABAB_ABAB; wb_dest_o = 0.
- LD.W at addr 0x0002 -> no bus_req_o; misalign_o = 1 with wb_valid_o; wb_dest_o = 0.
- rst asserted in BUS, then ack 2 cycles later -> bus_req_o = 0 at the next edge, no wb_valid_o, ready_o = 1. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4 and no ack -> timeout_o pulses after 4 BUS cycles.
